// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO typedefs and helpers
//
// Purpose: typedefs and helpers used by the FIFO and by the blocks that
//          sit around it.
//   arb_state_t : write-port arbiter state (ARB = arbitrate every beat,
//                 LOCK = grant held by one requester for a packet)
//   idx_w()     : width of an index into n items (at least 1 bit)
package fifo_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_m.sv
// rtl/rr_pick_m.sv - combinational round-robin picker
//
// Purpose: returns the first set request bit, searching upward from ptr+1
//          and wrapping from N-1 to 0, so ptr always has the lowest
//          priority.
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  index of the most recently served requester
//   winner out IW  selected index (0 when nothing is requested)
//   found  out 1   at least one request bit is set
module rr_pick_m
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    // Arithmetic modulo N, so a non-power-of-two N wraps from N-1 to 0.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb_m.sv
// rtl/fifo_wr_arb_m.sv - round-robin arbiter for the FIFO push side
//
// Purpose: lets N valid/ready requesters share the push side of one FIFO.
//          Each beat is arbitrated separately, or with PACKET_MODE="yes"
//          the grant is held from the first beat of a packet to its last.
// Ports:
//   clk          in  1        FIFO write clock
//   rst          in  1        asynchronous reset, active high
//   req_data     in  N items  item offered by each requester
//   req_valid    in  N        item valid for each requester
//   req_last     in  N        last beat of a packet (packet mode only)
//   req_ready    out N        accept for each requester
//   tail         out item     to FIFO tail
//   push         out 1        to FIFO push
//   full         in  1        from FIFO full
//   wr_rst_busy  in  1        from FIFO wr_rst_busy
//   grant_id     out clog2(N) most recently accepted requester
//   locked       out 1        packet in progress
module fifo_wr_arb_m
  import fifo_pkg::*;
#(
  parameter int    N              = 4,
  parameter type   DATA_ITEM_TYPE = logic,
  parameter string PACKET_MODE    = "no"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  DATA_ITEM_TYPE        req_data [N],
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output DATA_ITEM_TYPE        tail,
  output logic                 push,
  input  logic                 full,
  input  logic                 wr_rst_busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 locked
);

  localparam int IW  = idx_w(N);
  localparam bit PKT = (PACKET_MODE == "yes");

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner, owner_nxt;
  logic [N-1:0]  cand;
  logic [IW-1:0] winner;
  logic          found;
  logic          can_push;
  logic          accept;

  // During a packet only the owner may compete, even when its valid is low,
  // so that a stalled owner keeps the lock.
  assign cand     = (state == LOCK) ? (req_valid & (N'(1) << owner)) : req_valid;
  assign can_push = !full && !wr_rst_busy && !rst;
  assign accept   = found && can_push;

  rr_pick_m #(.N(N), .IW(IW)) u_pick (
    .req    (cand),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    req_ready = '0;
    push      = accept;
    tail      = '0;
    if (found && can_push) req_ready[winner] = 1'b1;
    if (found && !rst)     tail = req_data[winner];
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if (PKT && accept) begin
      case (state)
        ARB: begin
          // A single-beat packet never enters LOCK.
          if (!req_last[winner]) begin
            state_nxt = LOCK;
            owner_nxt = winner;
          end
        end
        LOCK: begin
          if (req_last[winner]) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      owner    <= '0;
      ptr      <= IW'(N - 1);
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (accept) begin
        ptr      <= winner;
        grant_id <= winner;
      end
    end
  end

  assign locked = PKT && (state == LOCK);

endmodule

// File: tb/tb_fifo_wr_arb_m.sv
// tb/tb_fifo_wr_arb_m.sv - directed testbench for fifo_wr_arb_m
module tb_fifo_wr_arb_m;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_data [4];
  logic [3:0] req_valid, req_last;
  logic       full, wr_rst_busy;

  logic [3:0] ready_rr, ready_pk;
  logic [7:0] tail_rr, tail_pk;
  logic       push_rr, push_pk;
  logic [1:0] grant_rr, grant_pk;
  logic       locked_rr, locked_pk;

  int n_checks = 0;
  int n_fail   = 0;

  // full back-pressure sequence and expected ids on the unblocked cycles
  bit fseq [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
  int eid  [8] = '{0, 1, 0, 0, 0, 2, 3, 0};

  // packet scenario, one row per cycle
  logic [3:0] pk_valid [7] = '{4'b0010, 4'b1011, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1001};
  logic [7:0] pk_data1 [7] = '{8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h23, 8'h23};
  logic [3:0] pk_last  [7] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1011};
  logic       pk_push  [7] = '{1, 1, 0, 0, 1, 1, 1};
  logic [3:0] pk_ready [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b1000};
  logic [7:0] pk_tail  [7] = '{8'h20, 8'h21, 8'h00, 8'h00, 8'h22, 8'h23, 8'h13};
  logic       pk_lock  [7] = '{0, 1, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  fifo_wr_arb_m #(.N(4), .DATA_ITEM_TYPE(logic [7:0]), .PACKET_MODE("no")) dut_rr (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(ready_rr), .tail(tail_rr), .push(push_rr),
    .full(full), .wr_rst_busy(wr_rst_busy), .grant_id(grant_rr), .locked(locked_rr)
  );

  fifo_wr_arb_m #(.N(4), .DATA_ITEM_TYPE(logic [7:0]), .PACKET_MODE("yes")) dut_pk (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(ready_pk), .tail(tail_pk), .push(push_pk),
    .full(full), .wr_rst_busy(wr_rst_busy), .grant_id(grant_pk), .locked(locked_pk)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; full = 1'b0; wr_rst_busy = 1'b0;
    req_valid = '0; req_last = '0;
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    n_checks++; if (push_rr !== 1'b0) begin n_fail++; $display("FAIL reset_push got %b want 0", push_rr); end
    n_checks++; if (ready_rr !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", ready_rr); end
    n_checks++; if (tail_rr !== 8'h00) begin n_fail++; $display("FAIL reset_tail got %h want 00", tail_rr); end
    n_checks++; if (push_pk !== 1'b0) begin n_fail++; $display("FAIL reset_push_pk got %b want 0", push_pk); end
    tick();
    n_checks++; if (grant_rr !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", grant_rr); end
    n_checks++; if (locked_pk !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked_pk); end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (push_rr !== 1'b1) begin n_fail++; $display("FAIL rot_push[%0d] got %b want 1", k, push_rr); end
      n_checks++; if (ready_rr !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rot_ready[%0d] got %b want %b", k, ready_rr, 4'(1 << (k % 4))); end
      n_checks++; if (tail_rr !== 8'h10 + 8'(k % 4)) begin n_fail++; $display("FAIL rot_tail[%0d] got %h want %h", k, tail_rr, 8'h10 + 8'(k % 4)); end
      n_checks++; if (grant_rr !== 2'((k == 0) ? 0 : (k - 1) % 4)) begin n_fail++; $display("FAIL rot_grant[%0d] got %0d want %0d", k, grant_rr, (k == 0) ? 0 : (k - 1) % 4); end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data[2] = 8'hA5; req_last = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (push_rr !== 1'b1) begin n_fail++; $display("FAIL single_push[%0d] got %b want 1", k, push_rr); end
      n_checks++; if (tail_rr !== 8'hA5) begin n_fail++; $display("FAIL single_tail[%0d] got %h want a5", k, tail_rr); end
      n_checks++; if (ready_rr !== 4'b0100) begin n_fail++; $display("FAIL single_ready[%0d] got %b want 0100", k, ready_rr); end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      full = fseq[i];
      #1;
      if (fseq[i]) begin
        n_checks++; if (push_rr !== 1'b0 || ready_rr !== 4'b0000) begin n_fail++; $display("FAIL full_block[%0d] got push=%b ready=%b want 0/0000", i, push_rr, ready_rr); end
        n_checks++; if (grant_rr !== 2'd1) begin n_fail++; $display("FAIL full_grant[%0d] got %0d want 1", i, grant_rr); end
      end else begin
        n_checks++; if (push_rr !== 1'b1) begin n_fail++; $display("FAIL full_push[%0d] got %b want 1", i, push_rr); end
        n_checks++; if (ready_rr !== 4'(1 << eid[i])) begin n_fail++; $display("FAIL full_ready[%0d] got %b want %b", i, ready_rr, 4'(1 << eid[i])); end
      end
      tick();
    end
    full = 1'b0;
  endtask

  task automatic test_packet();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = pk_valid[c]; req_data[1] = pk_data1[c]; req_last = pk_last[c];
      #1;
      n_checks++; if (push_pk !== pk_push[c]) begin n_fail++; $display("FAIL pkt_push[%0d] got %b want %b", c, push_pk, pk_push[c]); end
      n_checks++; if (ready_pk !== pk_ready[c]) begin n_fail++; $display("FAIL pkt_ready[%0d] got %b want %b", c, ready_pk, pk_ready[c]); end
      n_checks++; if (tail_pk !== pk_tail[c]) begin n_fail++; $display("FAIL pkt_tail[%0d] got %h want %h", c, tail_pk, pk_tail[c]); end
      n_checks++; if (locked_pk !== pk_lock[c]) begin n_fail++; $display("FAIL pkt_locked[%0d] got %b want %b", c, locked_pk, pk_lock[c]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000;
    #1;
    tick();
    req_valid = 4'b1111;
    #1;
    n_checks++; if (locked_pk !== 1'b1 || ready_pk !== 4'b0100) begin n_fail++; $display("FAIL midrst_lock got locked=%b ready=%b want 1/0100", locked_pk, ready_pk); end
    rst = 1'b1;
    #1;
    n_checks++; if (locked_pk !== 1'b0) begin n_fail++; $display("FAIL midrst_locked got %b want 0", locked_pk); end
    n_checks++; if (push_pk !== 1'b0 || ready_pk !== 4'b0000 || tail_pk !== 8'h00) begin n_fail++; $display("FAIL midrst_out got push=%b ready=%b tail=%h want 0/0000/00", push_pk, ready_pk, tail_pk); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (push_pk !== 1'b1 || ready_pk !== 4'b0001 || tail_pk !== 8'h10) begin n_fail++; $display("FAIL midrst_first got push=%b ready=%b tail=%h want 1/0001/10", push_pk, ready_pk, tail_pk); end
    n_checks++; if (ready_rr !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_rr got %b want 0001", ready_rr); end
    tick();
  endtask

  task automatic test_wr_rst_busy();
    rst = 1'b1; wr_rst_busy = 1'b1; full = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (push_rr !== 1'b0 || ready_rr !== 4'b0000) begin n_fail++; $display("FAIL busy_block[%0d] got push=%b ready=%b want 0/0000", i, push_rr, ready_rr); end
      tick();
    end
    wr_rst_busy = 1'b0;
    #1;
    n_checks++; if (push_rr !== 1'b1 || ready_rr !== 4'b0001 || tail_rr !== 8'h10) begin n_fail++; $display("FAIL busy_first got push=%b ready=%b tail=%h want 1/0001/10", push_rr, ready_rr, tail_rr); end
    tick();
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; wr_rst_busy = 1'b0;
    req_valid = '0; req_last = '0;
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    test_reset();
    test_rotation();
    test_single();
    test_full();
    test_packet();
    test_reset_mid_packet();
    test_wr_rst_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
